// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - core, cache-array and memory signal bundle for cache_refill_ctrl
// Optional PERF_CNT_EN adds the hit/miss counter outputs to the bundle.
interface cache_refill_ctrl_if #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam int WORD_W   = $clog2(WORDS_PER_LINE);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_ready_o;
    logic              rsp_valid_o;
    logic              rsp_hit_o;
    logic [DATA_W-1:0] rsp_data_o;

    logic [ADDR_W-1:0] lookup_addr_o;
    logic              cache_hit_i;
    logic [DATA_W-1:0] cache_data_i;

    logic               fill_we_o;
    logic [INDEX_W-1:0] fill_index_o;
    logic [WORD_W-1:0]  fill_word_o;
    logic [TAG_W-1:0]   fill_tag_o;
    logic [DATA_W-1:0]  fill_data_o;
    logic               fill_last_o;

    logic              mem_req_valid_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_req_ready_i;
    logic              mem_rsp_valid_i;
    logic [DATA_W-1:0] mem_rsp_data_i;

`ifdef PERF_CNT_EN
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;
`endif

    modport master (
        input  req_valid_i, req_addr_i, cache_hit_i, cache_data_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o, lookup_addr_o,
               fill_we_o, fill_index_o, fill_word_o, fill_tag_o, fill_data_o, fill_last_o,
`ifdef PERF_CNT_EN
               hit_cnt_o, miss_cnt_o,
`endif
               mem_req_valid_o, mem_req_addr_o
    );

    modport slave (
        output req_valid_i, req_addr_i, cache_hit_i, cache_data_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o, lookup_addr_o,
               fill_we_o, fill_index_o, fill_word_o, fill_tag_o, fill_data_o, fill_last_o,
`ifdef PERF_CNT_EN
               hit_cnt_o, miss_cnt_o,
`endif
               mem_req_valid_o, mem_req_addr_o
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped cache lookup and line-refill sequencer
// Optional PERF_CNT_EN adds saturating hit/miss counters.
module cache_refill_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    cache_refill_ctrl_if.master bus
);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam int WORD_W   = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W   = OFFSET_W - WORD_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_RSP, RESPOND} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lookup_addr_q, lookup_addr_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] capt_q, capt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              fill_we_q, fill_we_d;
    logic              fill_last_q, fill_last_d;
    logic [WORD_W-1:0] fill_word_q, fill_word_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic [WORD_W-1:0] req_word;

    assign req_word = lookup_addr_q[OFFSET_W-1:BYTE_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            lookup_addr_q <= '0;
            beat_q        <= '0;
            capt_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_data_q    <= '0;
            fill_we_q     <= 1'b0;
            fill_last_q   <= 1'b0;
            fill_word_q   <= '0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            lookup_addr_q <= lookup_addr_d;
            beat_q        <= beat_d;
            capt_q        <= capt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_data_q    <= rsp_data_d;
            fill_we_q     <= fill_we_d;
            fill_last_q   <= fill_last_d;
            fill_word_q   <= fill_word_d;
            fill_data_q   <= fill_data_d;
        end
    end

    // Outputs that must appear one cycle after their cause are computed here and registered above.
    always_comb begin
        state_d       = state_q;
        lookup_addr_d = lookup_addr_q;
        beat_d        = beat_q;
        capt_d        = capt_q;
        rsp_valid_d   = 1'b0;
        rsp_hit_d     = rsp_hit_q;
        rsp_data_d    = rsp_data_q;
        fill_we_d     = 1'b0;
        fill_last_d   = 1'b0;
        fill_word_d   = fill_word_q;
        fill_data_d   = fill_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    lookup_addr_d = bus.req_addr_i;
                    state_d       = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cache_hit_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_data_d  = bus.cache_data_i;
                    state_d     = IDLE;
                end else begin
                    beat_d  = '0;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready_i) begin
                    state_d = MEM_RSP;
                end
            end
            MEM_RSP: begin
                if (bus.mem_rsp_valid_i) begin
                    fill_we_d   = 1'b1;
                    fill_word_d = beat_q;
                    fill_data_d = bus.mem_rsp_data_i;
                    beat_d      = beat_q + WORD_W'(1);
                    if (beat_q == req_word) begin
                        capt_d = bus.mem_rsp_data_i;
                    end
                    if (beat_q == LAST_BEAT) begin
                        fill_last_d = 1'b1;
                        state_d     = RESPOND;
                    end
                end
            end
            RESPOND: begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_data_d  = capt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_hit_o       = rsp_hit_q;
    assign bus.rsp_data_o      = rsp_data_q;
    assign bus.lookup_addr_o   = lookup_addr_q;
    assign bus.mem_req_valid_o = (state_q == MEM_REQ);
    assign bus.mem_req_addr_o  = {lookup_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign bus.fill_we_o       = fill_we_q;
    assign bus.fill_last_o     = fill_last_q;
    assign bus.fill_word_o     = fill_word_q;
    assign bus.fill_data_o     = fill_data_q;
    assign bus.fill_index_o    = lookup_addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign bus.fill_tag_o      = lookup_addr_q[ADDR_W-1:INDEX_W+OFFSET_W];

`ifdef PERF_CNT_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (bus.cache_hit_i) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed self-checking bench for cache_refill_ctrl
// Optional PERF_CNT_EN enables the counter checks.
module tb_cache_refill_ctrl;
    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    cache_refill_ctrl_if bus ();

    cache_refill_ctrl dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns at the negedge while the DUT is in LOOKUP.
    task automatic start_req(input logic [15:0] addr, input logic hit, input logic [31:0] data);
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = addr;
        bus.cache_hit_i  = hit;
        bus.cache_data_i = data;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        chk("lookup_ready", bus.req_ready_o, 1'b0);
        chk("lookup_addr", bus.lookup_addr_o, addr);
        chk("lookup_rsp_valid", bus.rsp_valid_o, 1'b0);
    endtask

    task automatic mem_handshake(input logic [15:0] line);
        @(negedge clk_i);
        chk("memreq_valid", bus.mem_req_valid_o, 1'b1);
        chk("memreq_addr", bus.mem_req_addr_o, line);
        chk("memreq_ready", bus.req_ready_o, 1'b0);
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.mem_req_ready_i = 1'b0;
        chk("memreq_drop", bus.mem_req_valid_o, 1'b0);
    endtask

    task automatic send_beats(input logic [31:0] base, input int n,
                              input logic [5:0] idx, input logic [5:0] tag);
        for (int i = 0; i < n; i++) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = base + 32'(i);
            @(posedge clk_i);
            @(negedge clk_i);
            chk("fill_we", bus.fill_we_o, 1'b1);
            chk("fill_word", bus.fill_word_o, 64'(i));
            chk("fill_data", bus.fill_data_o, base + 32'(i));
            chk("fill_index", bus.fill_index_o, idx);
            chk("fill_tag", bus.fill_tag_o, tag);
            chk("fill_last", bus.fill_last_o, (i == 3));
        end
        bus.mem_rsp_valid_i = 1'b0;
    endtask

    task automatic check_rsp(input logic hit, input logic [31:0] data);
        @(negedge clk_i);
        chk("rsp_valid", bus.rsp_valid_o, 1'b1);
        chk("rsp_hit", bus.rsp_hit_o, hit);
        chk("rsp_data", bus.rsp_data_o, data);
        chk("rsp_fill_we", bus.fill_we_o, 1'b0);
        @(negedge clk_i);
        chk("rsp_pulse", bus.rsp_valid_o, 1'b0);
        chk("rsp_idle_ready", bus.req_ready_o, 1'b1);
    endtask

    initial begin
        rst_i               = 1'b1;
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.cache_hit_i     = 1'b0;
        bus.cache_data_i    = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;

        // reset
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", bus.req_ready_o, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_fill_we", bus.fill_we_o, 1'b0);
        chk("rst_fill_last", bus.fill_last_o, 1'b0);
        chk("rst_mem_req", bus.mem_req_valid_o, 1'b0);
        chk("rst_lookup_addr", bus.lookup_addr_o, 16'h0000);
        rst_i = 1'b0;

        // hit: response two edges after accept, no memory request
        start_req(16'h0040, 1'b1, 32'hDEADBEEF);
        chk("hit_no_memreq", bus.mem_req_valid_o, 1'b0);
        check_rsp(1'b1, 32'hDEADBEEF);
        chk("hit_no_memreq_after", bus.mem_req_valid_o, 1'b0);

        // miss 0x1234: line 0x1230, index 0x23, tag 0x4, word 1
        start_req(16'h1234, 1'b0, 32'h0);
        mem_handshake(16'h1230);
        send_beats(32'hA0, 4, 6'h23, 6'h04);
        check_rsp(1'b0, 32'hA1);
`ifdef PERF_CNT_EN
        chk("perf_hit", bus.hit_cnt_o, 16'd1);
        chk("perf_miss", bus.miss_cnt_o, 16'd1);
`endif

        // memory backpressure with a request arriving while busy
        start_req(16'h0100, 1'b0, 32'h0);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("bp_valid", bus.mem_req_valid_o, 1'b1);
            chk("bp_addr", bus.mem_req_addr_o, 16'h0100);
            chk("bp_ready", bus.req_ready_o, 1'b0);
            chk("bp_lookup_addr", bus.lookup_addr_o, 16'h0100);
        end
        bus.req_valid_i     = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.mem_req_ready_i = 1'b0;
        send_beats(32'hB0, 4, 6'h10, 6'h00);
        check_rsp(1'b0, 32'hB0);

        // reset after two of four beats
        start_req(16'h0ABC, 1'b0, 32'h0);
        mem_handshake(16'h0AB0);
        send_beats(32'hC0, 2, 6'h2B, 6'h02);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mid_rst_fill_we", bus.fill_we_o, 1'b0);
        chk("mid_rst_fill_last", bus.fill_last_o, 1'b0);
        chk("mid_rst_ready", bus.req_ready_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("mid_rst_no_rsp", bus.rsp_valid_o, 1'b0);
            chk("mid_rst_no_last", bus.fill_last_o, 1'b0);
        end
        start_req(16'h0ABC, 1'b0, 32'h0);
        mem_handshake(16'h0AB0);
        send_beats(32'hC0, 4, 6'h2B, 6'h02);
        check_rsp(1'b0, 32'hC3);

        // stray beats while idle must not fill or advance the beat count
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hEE;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("stray_fill_we", bus.fill_we_o, 1'b0);
            chk("stray_ready", bus.req_ready_o, 1'b1);
        end
        bus.mem_rsp_valid_i = 1'b0;
        start_req(16'h0008, 1'b0, 32'h0);
        mem_handshake(16'h0000);
        send_beats(32'hD0, 4, 6'h00, 6'h00);
        check_rsp(1'b0, 32'hD2);
`ifdef PERF_CNT_EN
        chk("perf_hit_end", bus.hit_cnt_o, 16'd0);
        chk("perf_miss_end", bus.miss_cnt_o, 16'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
